// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD controller, 4-bit bus, self-initialising, byte handshake.
// Define LCD_CURSOR_TRACK_EN to auto-wrap to the other line after column 16.
module lcd_ctrl #(
    parameter int T_PWRON = 750000,
    parameter int T_AS    = 4,
    parameter int T_EPW   = 12,
    parameter int T_NIB   = 50,
    parameter int T_CMD   = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic [3:0] dataout,
    output logic [2:0] control
);
    localparam int M1 = (T_PWRON > T_LONG) ? T_PWRON : T_LONG;
    localparam int M2 = (T_CMD > T_NIB) ? T_CMD : T_NIB;
    localparam int M3 = (T_AS > T_EPW) ? T_AS : T_EPW;
    localparam int M4 = (M2 > M3) ? M2 : M3;
    localparam int MX = (M1 > M4) ? M1 : M4;
    localparam int W  = (MX > 1) ? $clog2(MX) : 1;

    localparam logic [W-1:0] L_PWRON = W'(T_PWRON - 1);
    localparam logic [W-1:0] L_AS    = W'(T_AS - 1);
    localparam logic [W-1:0] L_EPW   = W'(T_EPW - 1);
    localparam logic [W-1:0] L_NIB   = W'(T_NIB - 1);
    localparam logic [W-1:0] L_CMD   = W'(T_CMD - 1);
    localparam logic [W-1:0] L_LONG  = W'(T_LONG - 1);

    typedef enum logic [3:0] {
        S_PWR_WAIT, S_INIT, S_IDLE,
        S_SETUP_H, S_E_H, S_GAP_H,
        S_SETUP_L, S_E_L, S_GAP_L,
        S_EXEC
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   w_load;
    logic [2:0]     r_step;
    logic           r_init_done;
    logic [7:0]     r_data;
    logic           r_rs;
    logic           r_long;
    logic [7:0]     w_init_byte;
    logic           w_init_long;
    logic           w_done;
    logic           w_accept;
    logic           w_exec_done;
    logic           w_is_clr;
    logic           w_e;
    logic           w_rs_o;
    logic           w_wrap;
    logic           w_pend;
    logic [7:0]     w_pbyte;
    logic [7:0]     w_wrap_cmd;

    assign w_done      = (r_cnt == '0);
    assign in_ready    = (r_state == S_IDLE) & r_init_done;
    assign init_done   = r_init_done;
    assign w_accept    = in_valid & in_ready;
    assign w_exec_done = (r_state == S_EXEC) & w_done;
    assign w_is_clr    = ~in_rs & (in_data[7:2] == 6'd0) & (in_data[1:0] != 2'd0);

    // Steps 0-3 are lone 8-bit-mode nibbles, 4-7 are full bytes.
    always_comb begin
        w_init_byte = 8'h00;
        w_init_long = 1'b0;
        case (r_step)
            3'd0: begin w_init_byte = 8'h03; w_init_long = 1'b1; end
            3'd1: w_init_byte = 8'h03;
            3'd2: w_init_byte = 8'h03;
            3'd3: w_init_byte = 8'h02;
            3'd4: w_init_byte = 8'h28;
            3'd5: w_init_byte = 8'h0C;
            3'd6: w_init_byte = 8'h06;
            default: begin w_init_byte = 8'h01; w_init_long = 1'b1; end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_PWR_WAIT: if (w_done) w_state_nxt = S_INIT;
            S_INIT:     w_state_nxt = r_step[2] ? S_SETUP_H : S_SETUP_L;
            S_IDLE:     if (w_accept) w_state_nxt = S_SETUP_H;
            S_SETUP_H:  if (w_done) w_state_nxt = S_E_H;
            S_E_H:      if (w_done) w_state_nxt = S_GAP_H;
            S_GAP_H:    if (w_done) w_state_nxt = S_SETUP_L;
            S_SETUP_L:  if (w_done) w_state_nxt = S_E_L;
            S_E_L:      if (w_done) w_state_nxt = S_GAP_L;
            S_GAP_L:    if (w_done) w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (w_done) begin
                    if (!r_init_done)
                        w_state_nxt = (r_step == 3'd7) ? S_IDLE : S_INIT;
                    else if (w_pend)
                        w_state_nxt = S_SETUP_H;
                    else
                        w_state_nxt = S_IDLE;
                end
            end
            default:    w_state_nxt = S_PWR_WAIT;
        endcase
    end

    always_comb begin
        w_load = '0;
        case (w_state_nxt)
            S_PWR_WAIT:           w_load = L_PWRON;
            S_SETUP_H, S_SETUP_L: w_load = L_AS;
            S_E_H, S_E_L:         w_load = L_EPW;
            S_GAP_H, S_GAP_L:     w_load = L_NIB;
            S_EXEC:               w_load = r_long ? L_LONG : L_CMD;
            default:              w_load = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PWR_WAIT;
            r_cnt   <= L_PWRON;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_cnt <= w_load;
            else if (!w_done)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_long      <= 1'b0;
            r_step      <= 3'd0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_data <= w_init_byte;
                r_rs   <= 1'b0;
                r_long <= w_init_long;
            end else if (w_accept) begin
                r_data <= w_wrap ? w_wrap_cmd : in_data;
                r_rs   <= in_rs & ~w_wrap;
                r_long <= w_is_clr;
            end else if (w_exec_done & w_pend) begin
                r_data <= w_pbyte;
                r_rs   <= 1'b1;
                r_long <= 1'b0;
            end
            if (w_exec_done & ~r_init_done) begin
                r_step <= r_step + 3'd1;
                if (r_step == 3'd7)
                    r_init_done <= 1'b1;
            end
        end
    end

`ifdef LCD_CURSOR_TRACK_EN
    logic [4:0] r_col;
    logic       r_line;
    logic       r_pend;
    logic [7:0] r_pbyte;

    assign w_wrap     = in_rs & (r_col == 5'd16);
    assign w_wrap_cmd = r_line ? 8'h80 : 8'hC0;
    assign w_pend     = r_pend;
    assign w_pbyte    = r_pbyte;

    // A wrapping data byte is parked while the line-move command goes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= 5'd0;
            r_line  <= 1'b0;
            r_pend  <= 1'b0;
            r_pbyte <= 8'h00;
        end else if (w_accept) begin
            r_pend  <= w_wrap;
            r_pbyte <= in_data;
            if (w_wrap) begin
                r_col  <= 5'd1;
                r_line <= ~r_line;
            end else if (in_rs) begin
                r_col <= r_col + 5'd1;
            end else if (w_is_clr) begin
                r_col  <= 5'd0;
                r_line <= 1'b0;
            end else if (in_data[7]) begin
                r_line <= in_data[6];
                r_col  <= {1'b0, in_data[3:0]};
            end
        end else if (w_exec_done) begin
            r_pend <= 1'b0;
        end
    end
`else
    assign w_wrap     = 1'b0;
    assign w_wrap_cmd = 8'h00;
    assign w_pend     = 1'b0;
    assign w_pbyte    = 8'h00;
`endif

    always_comb begin
        dataout = 4'h0;
        w_e     = 1'b0;
        w_rs_o  = 1'b0;
        case (r_state)
            S_SETUP_H, S_GAP_H: begin
                dataout = r_data[7:4];
                w_rs_o  = r_rs;
            end
            S_E_H: begin
                dataout = r_data[7:4];
                w_rs_o  = r_rs;
                w_e     = 1'b1;
            end
            S_SETUP_L, S_GAP_L: begin
                dataout = r_data[3:0];
                w_rs_o  = r_rs;
            end
            S_E_L: begin
                dataout = r_data[3:0];
                w_rs_o  = r_rs;
                w_e     = 1'b1;
            end
            default: ;
        endcase
    end

    assign control = {w_e, w_rs_o, 1'b0};

endmodule
